// File: rtl/fetch_ifid_stage_if.sv
// Handshake bundle between the fetch/IF-ID stage and its neighbours: the loader,
// the hazard unit, and decode. The stage uses the slave modport.
interface fetch_ifid_stage_if #(
    parameter int IMEM_DEPTH = 256
);
    localparam int CW = $clog2(IMEM_DEPTH) + 1;

    logic          loadEn;
    logic [31:0]   loadData;
    logic          start;
    logic          stall;
    logic          pcSrc;
    logic [31:0]   branchTarget;
    logic [31:0]   ifidIr;
    logic [31:0]   ifidPc;
    logic          running;
    logic [CW-1:0] loadCount;

    modport master (
        output loadEn, loadData, start, stall, pcSrc, branchTarget,
        input  ifidIr, ifidPc, running, loadCount
    );

    modport slave (
        input  loadEn, loadData, start, stall, pcSrc, branchTarget,
        output ifidIr, ifidPc, running, loadCount
    );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch stage with IF/ID pipeline register and a sequentially loaded
// instruction memory. Define FETCH_HALT_EN to add a HALT state on opcode 6'b111111.
module fetch_ifid_stage #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input logic               clk_i,
    input logic               rst_ni,
    fetch_ifid_stage_if.slave bus
);
    localparam int A  = $clog2(IMEM_DEPTH);
    localparam int CW = A + 1;
    localparam logic [CW-1:0] COUNT_MAX = CW'(IMEM_DEPTH);

`ifdef FETCH_HALT_EN
    localparam logic [5:0] HALT_OP = 6'b111111;
    typedef enum logic [1:0] {LOAD, RUN, HALT} state_t;
`else
    typedef enum logic [0:0] {LOAD, RUN} state_t;
`endif

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [A-1:0]  loadPtr_q, loadPtr_d;
    logic [CW-1:0] loadCount_q, loadCount_d;
    logic [31:0]   ifidIr_q, ifidIr_d;
    logic [31:0]   ifidPc_q, ifidPc_d;
    logic          running_q, running_d;
    logic          memWe;
    logic [31:0]   fetchWord;
    logic [31:0]   pcPlus4;

    logic [31:0] imem [IMEM_DEPTH];

    // Upper PC bits are ignored so fetches wrap around the memory.
    assign fetchWord = imem[pc_q[A+1:2]];
    assign pcPlus4   = pc_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        loadPtr_d   = loadPtr_q;
        loadCount_d = loadCount_q;
        ifidIr_d    = ifidIr_q;
        ifidPc_d    = ifidPc_q;
        running_d   = running_q;
        memWe       = 1'b0;
        case (state_q)
            LOAD: begin
                if (bus.loadEn) begin
                    memWe     = 1'b1;
                    loadPtr_d = loadPtr_q + 1'b1;
                    if (loadCount_q != COUNT_MAX)
                        loadCount_d = loadCount_q + 1'b1;
                end
                if (bus.start) begin
                    state_d   = RUN;
                    running_d = 1'b1;
                end
            end
            RUN: begin
`ifdef FETCH_HALT_EN
                if (!bus.pcSrc && ifidIr_q[31:26] == HALT_OP) begin
                    state_d   = HALT;
                    running_d = 1'b0;
                    ifidIr_d  = NOP_WORD;
                end else
`endif
                // A taken branch flushes IF/ID and beats any stall request.
                if (bus.pcSrc) begin
                    pc_d     = bus.branchTarget & ~32'h3;
                    ifidIr_d = NOP_WORD;
                    ifidPc_d = 32'h0;
                end else if (!bus.stall) begin
                    ifidIr_d = fetchWord;
                    ifidPc_d = pcPlus4;
                    pc_d     = pcPlus4;
                end
            end
`ifdef FETCH_HALT_EN
            HALT: begin
                ifidIr_d  = NOP_WORD;
                running_d = 1'b0;
            end
`endif
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= LOAD;
            pc_q        <= RESET_PC;
            loadPtr_q   <= '0;
            loadCount_q <= '0;
            ifidIr_q    <= NOP_WORD;
            ifidPc_q    <= 32'h0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            loadPtr_q   <= loadPtr_d;
            loadCount_q <= loadCount_d;
            ifidIr_q    <= ifidIr_d;
            ifidPc_q    <= ifidPc_d;
            running_q   <= running_d;
        end
    end

    // Program memory survives reset so a program can be re-run without reloading.
    always_ff @(posedge clk_i) begin
        if (memWe)
            imem[loadPtr_q] <= bus.loadData;
    end

    assign bus.ifidIr    = ifidIr_q;
    assign bus.ifidPc    = ifidPc_q;
    assign bus.running   = running_q;
    assign bus.loadCount = loadCount_q;
endmodule
